// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master
//   AHB-Lite master fed by a valid/ready command stream. Commands are queued in
//   a small registered FIFO, then issued as single NONSEQ transfers through an
//   address-phase register and a data-phase register. Read data is returned on
//   a one-cycle rsp_valid pulse, in command order.
//
// Ports
//   hclk, hresetn            clock, async active-low reset
//   cmd_valid/ready          command handshake (ready = FIFO not full)
//   cmd_addr/write/wdata     command payload (wdata ignored for reads)
//   rsp_valid/rsp_rdata      read response pulse / data
//   busy                     FIFO non-empty or any phase register occupied
//   hselx/haddr/hwrite/htrans/hwdata   AHB master outputs
//   hready/hrdata            AHB slave inputs
module ahb_cmd_master #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32,
  parameter int cmdDepth  = 4
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic                 cmd_write,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 hselx,
  output logic [addrWidth-1:0] haddr,
  output logic                 hwrite,
  output logic [1:0]           htrans,
  output logic [dataWidth-1:0] hwdata,
  input  logic                 hready,
  input  logic [dataWidth-1:0] hrdata
);

  localparam int PW = $clog2(cmdDepth);

  typedef struct packed {
    logic [addrWidth-1:0] addr;
    logic                 write;
    logic [dataWidth-1:0] wdata;
  } cmd_t;

  // FIFO storage: no reset needed, validity is tracked by cnt_q
  cmd_t fifo_q [cmdDepth];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]          cnt_q, cnt_d;
  logic                 ap_vld_q, ap_vld_d;
  cmd_t                 ap_q, ap_d;
  logic                 dp_vld_q, dp_vld_d;
  logic                 dp_write_q, dp_write_d;
  logic [dataWidth-1:0] dp_wdata_q, dp_wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

  logic empty, full, push, pop, hazard;
  cmd_t head;

  always_comb begin
    empty  = (cnt_q == '0);
    full   = (cnt_q == (PW+1)'(cmdDepth));
    head   = fifo_q[rd_ptr_q];
    push   = cmd_valid && !full;
    // A read must not be sampled by the slave in the same edge that completes
    // a preceding write's data phase; one IDLE slot lets the write land first.
    hazard = ap_vld_q && ap_q.write && !head.write;
    pop    = hready && !empty && !hazard;

    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    cnt_d       = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    ap_vld_d    = ap_vld_q;
    ap_d        = ap_q;
    dp_vld_d    = dp_vld_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    if (hready) begin
      dp_vld_d   = ap_vld_q;
      dp_write_d = ap_q.write;
      dp_wdata_d = ap_q.wdata;
      ap_vld_d   = pop;
      // ap_q keeps the last issued command while IDLE so haddr/hwrite hold
      if (pop) ap_d = head;
      if (dp_vld_q && !dp_write_q) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = hrdata;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: cmd_addr, write: cmd_write, wdata: cmd_wdata};
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ap_vld_q    <= 1'b0;
      ap_q        <= '0;
      dp_vld_q    <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ap_vld_q    <= ap_vld_d;
      ap_q        <= ap_d;
      dp_vld_q    <= dp_vld_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = !full;
  assign busy      = !empty || ap_vld_q || dp_vld_q;
  assign hselx     = ap_vld_q;
  assign htrans    = ap_vld_q ? 2'b10 : 2'b00;
  assign haddr     = ap_q.addr;
  assign hwrite    = ap_q.write;
  assign hwdata    = (dp_vld_q && dp_write_q) ? dp_wdata_q : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: an AHB memory slave with synchronous read (address
// sampled at the end of the address phase), a sequential-memory reference
// model, directed scenarios and a randomized run with random hready.
module tb_ahb_cmd_master;
  localparam int AW = 8, DW = 32, DEP = 4;

  logic hclk = 1'b0, hresetn = 1'b0;
  logic cmd_valid, cmd_ready, cmd_write, rsp_valid, busy, hselx, hwrite, hready;
  logic [AW-1:0] cmd_addr, haddr;
  logic [DW-1:0] cmd_wdata, rsp_rdata, hwdata, hrdata;
  logic [1:0]    htrans;

  always #5 hclk = ~hclk;

  ahb_cmd_master #(.addrWidth(AW), .dataWidth(DW), .cmdDepth(DEP)) dut (
    .hclk(hclk), .hresetn(hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .hselx(hselx),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata));

  int n_chk = 0, n_fail = 0, n_rsp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- AHB memory slave ----------------
  logic [DW-1:0] smem [256];
  logic          s_dp_vld, s_dp_write;
  logic [AW-1:0] s_dp_addr;
  logic [DW-1:0] s_rdata;
  assign hrdata = s_rdata;

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int a = 0; a < 256; a++) smem[a] <= pat(a);
      s_dp_vld <= 1'b0; s_dp_write <= 1'b0; s_dp_addr <= '0; s_rdata <= '0;
    end else if (hready) begin
      if (s_dp_vld && s_dp_write) smem[s_dp_addr] <= hwdata;
      s_dp_vld   <= hselx && (htrans == 2'b10);
      s_dp_write <= hwrite;
      s_dp_addr  <= haddr;
      if (hselx && htrans == 2'b10 && !hwrite) s_rdata <= smem[haddr];
    end
  end

  // ---------------- reference model ----------------
  // Commands take effect in acceptance order against a flat memory; every read
  // expects the value left by all earlier accepted writes.
  logic [DW-1:0] mdl [256];
  logic [DW-1:0] exp_q [$];

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      exp_q.delete();
      for (int a = 0; a < 256; a++) mdl[a] = pat(a);
    end else if (cmd_valid && cmd_ready) begin
      if (cmd_write) mdl[cmd_addr] = cmd_wdata;
      else           exp_q.push_back(mdl[cmd_addr]);
    end
  end

  // ---------------- protocol / response monitor ----------------
  logic          hr_edge;
  logic          prv_ok = 1'b0;
  logic [1:0]    prv_htrans;
  logic [AW-1:0] prv_haddr;

  always @(posedge hclk) hr_edge <= hready;

  always @(negedge hclk) begin
    if (hresetn) begin
      if (rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else                   chk("rsp_data", rsp_rdata, exp_q.pop_front());
      end
      chk("htrans_enc", (htrans == 2'b00) || (htrans == 2'b10), 1);
      chk("hselx_vs_htrans", hselx, htrans[1]);
      if (prv_ok && !hr_edge) begin
        chk("stall_htrans", htrans, prv_htrans);
        chk("stall_haddr", haddr, prv_haddr);
        chk("stall_no_rsp", rsp_valid, 0);
      end
      prv_htrans = htrans;
      prv_haddr  = haddr;
      prv_ok     = 1'b1;
    end else prv_ok = 1'b0;
  end

  // ---------------- stimulus helpers ----------------
  logic [AW-1:0] cq_a [$];
  logic          cq_w [$];
  logic [DW-1:0] cq_d [$];
  int            hr_pat [64];
  logic [1:0]    rec_tr [64];
  logic [AW-1:0] rec_a  [64];
  logic          rec_w  [64], rec_rv [64], rec_busy [64], rec_rdy [64];
  logic [DW-1:0] rec_wd [64], rec_rd [64];
  int            rec_n;

  task automatic step();
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic add_cmd(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    cq_a.push_back(a); cq_w.push_back(w); cq_d.push_back(d);
  endtask

  task automatic clr();
    cq_a.delete(); cq_w.delete(); cq_d.delete();
    for (int i = 0; i < 64; i++) hr_pat[i] = 1;
  endtask

  // Runs ncyc cycles offering the queued commands in order; sample i is taken
  // on the falling edge after rising edge i.
  task automatic run(input int ncyc);
    int  np;
    logic acc;
    np = 0;
    rec_n = ncyc;
    for (int i = 0; i < ncyc; i++) begin
      hready = (hr_pat[i] != 0);
      if (np < cq_a.size()) begin
        cmd_valid = 1'b1; cmd_addr = cq_a[np]; cmd_write = cq_w[np]; cmd_wdata = cq_d[np];
      end else cmd_valid = 1'b0;
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) np++;
      rec_tr[i] = htrans; rec_a[i] = haddr; rec_w[i] = hwrite; rec_wd[i] = hwdata;
      rec_rv[i] = rsp_valid; rec_rd[i] = rsp_rdata; rec_busy[i] = busy; rec_rdy[i] = cmd_ready;
    end
    cmd_valid = 1'b0;
    hready = 1'b1;
  endtask

  function automatic int first_ns();
    for (int i = 0; i < rec_n; i++) if (rec_tr[i] == 2'b10) return i;
    return -1;
  endfunction

  task automatic chk_reset(input string p);
    chk({p, "_htrans"}, htrans, 0);   chk({p, "_hselx"}, hselx, 0);
    chk({p, "_haddr"}, haddr, 0);     chk({p, "_hwrite"}, hwrite, 0);
    chk({p, "_hwdata"}, hwdata, 0);   chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_rdata"}, rsp_rdata, 0);
    chk({p, "_busy"}, busy, 0);       chk({p, "_cmd_ready"}, cmd_ready, 1);
  endtask

  int f, cnt, r0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_addr = '0; cmd_write = 0; cmd_wdata = '0; hready = 1;
    repeat (3) @(negedge hclk);
    chk_reset("rst_hold");
    hresetn = 1'b1;
    step();
    chk_reset("rst_rel");

    // write then read of the same address: one IDLE between them
    clr();
    add_cmd(8'h10, 1, 32'hDEADBEEF);
    add_cmd(8'h10, 0, '0);
    run(10);
    f = first_ns();
    chk("t1_latency", f, 1);
    if (f < 0) f = 0;
    chk("t1_w_trans", rec_tr[f], 2);     chk("t1_w_hwrite", rec_w[f], 1);
    chk("t1_w_haddr", rec_a[f], 8'h10);
    chk("t1_idle", rec_tr[f+1], 0);      chk("t1_idle_hold_w", rec_w[f+1], 1);
    chk("t1_idle_hold_a", rec_a[f+1], 8'h10);
    chk("t1_hwdata", rec_wd[f+1], 32'hDEADBEEF);
    chk("t1_r_trans", rec_tr[f+2], 2);   chk("t1_r_hwrite", rec_w[f+2], 0);
    chk("t1_r_haddr", rec_a[f+2], 8'h10);
    chk("t1_rd_hwdata0", rec_wd[f+3], 0);
    chk("t1_rsp_v", rec_rv[f+4], 1);     chk("t1_rsp_d", rec_rd[f+4], 32'hDEADBEEF);
    cnt = 0;
    for (int i = 0; i < rec_n; i++) cnt += int'(rec_rv[i]);
    chk("t1_rsp_once", cnt, 1);

    // six writes, FIFO filled while hready is low
    clr();
    for (int i = 0; i < 6; i++) add_cmd(AW'(i), 1, DW'(32'h100 + i));
    for (int i = 0; i < 4; i++) hr_pat[i] = 0;
    run(20);
    chk("t2_ready_3q", rec_rdy[2], 1);
    chk("t2_ready_full", rec_rdy[3], 0);
    f = first_ns();
    chk("t2_first", f, 4);
    if (f < 0) f = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t2_trans", rec_tr[f+i], 2);
      chk("t2_haddr", rec_a[f+i], AW'(i));
      chk("t2_hwdata_lag", rec_wd[f+i+1], DW'(32'h100 + i));
    end
    chk("t2_end_idle", rec_tr[f+6], 0);
    chk("t2_busy_dp", rec_busy[f+6], 1);
    chk("t2_busy_off", rec_busy[f+7], 0);

    // four back-to-back reads
    clr();
    for (int i = 0; i < 4; i++) add_cmd(AW'(i), 0, '0);
    run(12);
    f = first_ns();
    chk("t3_first", f, 1);
    if (f < 0) f = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_trans", rec_tr[f+i], 2);
      chk("t3_haddr", rec_a[f+i], AW'(i));
      chk("t3_rsp_v", rec_rv[f+2+i], 1);
      chk("t3_rsp_d", rec_rd[f+2+i], DW'(32'h100 + i));
    end
    chk("t3_rsp_end", rec_rv[f+6], 0);

    // 3-cycle stall during a read's address phase
    clr();
    add_cmd(8'h02, 0, '0);
    for (int i = 2; i < 5; i++) hr_pat[i] = 0;
    run(12);
    f = first_ns();
    chk("t4_first", f, 1);
    if (f < 0) f = 0;
    for (int k = 1; k < 4; k++) begin
      chk("t4_hold_trans", rec_tr[f+k], 2);
      chk("t4_hold_haddr", rec_a[f+k], 8'h02);
    end
    chk("t4_rsp_early", rec_rv[f+4], 0);
    chk("t4_rsp_v", rec_rv[f+5], 1);
    chk("t4_rsp_d", rec_rd[f+5], 32'h102);
    chk("t4_rsp_end", rec_rv[f+6], 0);

    // reset while a write is in data phase with two reads queued
    clr();
    add_cmd(8'h30, 1, 32'hCAFEF00D);
    add_cmd(8'h31, 0, '0);
    add_cmd(8'h32, 0, '0);
    run(3);
    chk("t5_pre_wdata", hwdata, 32'hCAFEF00D);
    chk("t5_pre_busy", busy, 1);
    hresetn = 1'b0;
    #1;
    chk_reset("t5_async");
    @(negedge hclk); @(negedge hclk);
    hresetn = 1'b1;
    r0 = n_rsp;
    clr();
    run(10);
    chk("t5_no_rsp", n_rsp - r0, 0);
    chk("t5_busy", rec_busy[9], 0);
    chk("t5_ready", rec_rdy[9], 1);
    chk("t5_rdata", rec_rd[9], 0);

    // read then write of same address: no IDLE, read sees the old value
    clr();
    add_cmd(8'h20, 0, '0);
    add_cmd(8'h20, 1, 32'h1234_5678);
    run(10);
    f = first_ns();
    if (f < 0) f = 0;
    chk("t6_r_trans", rec_tr[f], 2);   chk("t6_r_hwrite", rec_w[f], 0);
    chk("t6_w_trans", rec_tr[f+1], 2); chk("t6_w_hwrite", rec_w[f+1], 1);
    chk("t6_rsp_v", rec_rv[f+2], 1);   chk("t6_rsp_old", rec_rd[f+2], pat(32'h20));

    // randomized traffic with random hready
    for (int i = 0; i < 600; i++) begin
      hready    = ($urandom_range(0, 3) != 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_addr  = AW'($urandom_range(0, 15));
      cmd_write = $urandom_range(0, 1) != 0;
      cmd_wdata = $urandom;
      step();
    end
    cmd_valid = 1'b0;
    hready = 1'b1;
    cnt = 0;
    while (busy && cnt < 200) begin step(); cnt++; end
    chk("rand_drain", busy, 0);
    step(); step();
    chk("rand_all_rsp", exp_q.size(), 0);
    for (int a = 0; a < 16; a++) chk("rand_mem", smem[a], mdl[a]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
